// File: rtl/athena_dip_seq_pkg.sv
// Shared definitions for the DIP settings sequencer: store geometry,
// game codes, loader states and the per-game default settings tables.
package athena_dip_seq_pkg;

  localparam int DIP_NUM_ENTRIES  = 16;
  localparam int DIP_GAME_INDEX   = 15;
  localparam int DIP_LOAD_ENTRIES = 15;

  typedef logic [DIP_NUM_ENTRIES-1:0][7:0] dip_mem_t;

  typedef enum logic [7:0] {
    GAME_ATHENA        = 8'h00,
    GAME_FIGHTING_GOLF = 8'h01
  } game_e;

  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_LOAD = 1'b1
  } load_state_e;

  // Default value of one settings entry for a given game; any code that is
  // not a known game falls back to the athena table.
  function automatic logic [7:0] dip_default(game_e game, logic [3:0] idx);
    logic [7:0] athena_val;
    logic [7:0] golf_val;
    athena_val = 8'h00;
    golf_val   = 8'h00;
    case (idx)
      4'd0:  begin athena_val = 8'h3C; golf_val = 8'h11; end
      4'd1:  begin athena_val = 8'h01; golf_val = 8'h22; end
      4'd2:  begin athena_val = 8'h02; golf_val = 8'h33; end
      4'd3:  begin athena_val = 8'h10; golf_val = 8'h44; end
      4'd4:  begin athena_val = 8'h20; golf_val = 8'h05; end
      4'd5:  begin athena_val = 8'h03; golf_val = 8'h06; end
      4'd6:  begin athena_val = 8'h41; golf_val = 8'h17; end
      4'd7:  begin athena_val = 8'h08; golf_val = 8'h18; end
      4'd8:  begin athena_val = 8'h04; golf_val = 8'h09; end
      4'd9:  begin athena_val = 8'h50; golf_val = 8'h1A; end
      4'd10: begin athena_val = 8'h81; golf_val = 8'h0B; end
      4'd11: begin athena_val = 8'h0F; golf_val = 8'h0C; end
      4'd12: begin athena_val = 8'h05; golf_val = 8'h00; end
      4'd13: begin athena_val = 8'h66; golf_val = 8'h00; end
      4'd14: begin athena_val = 8'h07; golf_val = 8'h00; end
      default: begin athena_val = 8'h00; golf_val = 8'h00; end
    endcase
    if (game == GAME_FIGHTING_GOLF) begin
      return golf_val;
    end
    return athena_val;
  endfunction

endpackage

// File: rtl/athena_dip_seq_if.sv
// APF bridge access to the DIP settings store: single-cycle write and read
// strobes with an entry index, and a registered read data return.
interface athena_dip_seq_if;
  logic        wr;
  logic        rd;
  logic [3:0]  addr;
  logic [7:0]  wr_data;
  logic [31:0] rd_data;
  logic        rd_data_valid;

  modport master (
    output wr, rd, addr, wr_data,
    input  rd_data, rd_data_valid
  );

  modport slave (
    input  wr, rd, addr, wr_data,
    output rd_data, rd_data_valid
  );
endinterface

// File: rtl/athena_dip_seq_loader.sv
// Default-settings loader: walks entries 0..LOAD_ENTRIES-1 writing the
// selected game's defaults, yielding to every bridge write, skipping entries
// the host has already written and restarting when the game select changes.
module athena_dip_loader
  import athena_dip_seq_pkg::*;
#(
  parameter int GAME_INDEX   = DIP_GAME_INDEX,
  parameter int LOAD_ENTRIES = DIP_LOAD_ENTRIES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_req,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       ld_wr,
  output logic [3:0] ld_idx,
  output logic [7:0] ld_data,
  output logic       load_busy
);

  localparam logic [3:0] GAME_IDX   = 4'(GAME_INDEX);
  localparam logic [3:0] LAST_IDX   = 4'(LOAD_ENTRIES - 1);
  localparam logic [4:0] LOAD_LIMIT = 5'(LOAD_ENTRIES);

  load_state_e             state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic [LOAD_ENTRIES-1:0] dirty_q, dirty_d;
  logic [7:0]              target_q, target_d;
  logic                    restart;

  assign restart   = wr_req && (wr_addr == GAME_IDX) && (wr_data != target_q);
  assign ld_idx    = idx_q;
  assign ld_data   = dip_default(game_e'(target_q), idx_q);
  assign load_busy = (state_q == LD_LOAD);

  // Loader state register; reset starts a fresh load of game 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LD_LOAD;
      idx_q    <= '0;
      dirty_q  <= '0;
      target_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dirty_q  <= dirty_d;
      target_q <= target_d;
    end
  end

  // Next-state and loader write request; bridge writes always take the port.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dirty_d  = dirty_q;
    target_d = target_q;
    ld_wr    = 1'b0;
    case (state_q)
      LD_IDLE: begin
        if (restart) begin
          state_d  = LD_LOAD;
          idx_d    = '0;
          dirty_d  = '0;
          target_d = wr_data;
        end
      end
      LD_LOAD: begin
        if (restart) begin
          idx_d    = '0;
          dirty_d  = '0;
          target_d = wr_data;
        end else if (wr_req) begin
          if ({1'b0, wr_addr} < LOAD_LIMIT) begin
            dirty_d[wr_addr] = 1'b1;
          end
        end else begin
          ld_wr = ~dirty_q[idx_q];
          idx_d = idx_q + 4'd1;
          if (idx_q == LAST_IDX) begin
            state_d = LD_IDLE;
          end
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

endmodule

// File: rtl/athena_dip_seq.sv
// DIP settings sequencer top: settings store, bridge/loader write arbitration,
// registered read path and the live settings view for the DIP mapper.
// Optional macro ATHENA_DIP_VBLANK_APPLY_EN defers view updates to vblank.
module athena_dip_seq
  import athena_dip_seq_pkg::*;
#(
  parameter int NUM_ENTRIES  = DIP_NUM_ENTRIES,
  parameter int GAME_INDEX   = DIP_GAME_INDEX,
  parameter int LOAD_ENTRIES = DIP_LOAD_ENTRIES
) (
  input  logic                     clk,
  input  logic                     reset,
  athena_dip_seq_if.slave          bridge,
  input  logic                     vblank,
  output logic [NUM_ENTRIES*8-1:0] dip_entries,
  output logic [7:0]               game,
  output logic                     dip_ready,
  output logic                     load_busy
);

  logic [NUM_ENTRIES-1:0][7:0] store_q;
  logic [NUM_ENTRIES-1:0][7:0] view_q;
  logic [7:0]                  game_q;
  logic                        ld_wr;
  logic [3:0]                  ld_idx;
  logic [7:0]                  ld_data;
  logic                        apply;

  athena_dip_loader #(
    .GAME_INDEX   (GAME_INDEX),
    .LOAD_ENTRIES (LOAD_ENTRIES)
  ) u_loader (
    .clk       (clk),
    .reset     (reset),
    .wr_req    (bridge.wr),
    .wr_addr   (bridge.addr),
    .wr_data   (bridge.wr_data),
    .ld_wr     (ld_wr),
    .ld_idx    (ld_idx),
    .ld_data   (ld_data),
    .load_busy (load_busy)
  );

  // Single store write port: the bridge wins over the default loader.
  always_ff @(posedge clk) begin
    if (reset) begin
      store_q <= '0;
    end else if (bridge.wr) begin
      store_q[bridge.addr] <= bridge.wr_data;
    end else if (ld_wr) begin
      store_q[ld_idx] <= ld_data;
    end
  end

  // Read pipe: one-cycle latency, returns the value before a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      bridge.rd_data       <= 32'h0;
      bridge.rd_data_valid <= 1'b0;
    end else begin
      bridge.rd_data       <= {24'h0, store_q[bridge.addr]};
      bridge.rd_data_valid <= bridge.rd;
    end
  end

`ifdef ATHENA_DIP_VBLANK_APPLY_EN
  logic vblank_q;
  logic first_done_q;
  logic first_apply;

  assign first_apply = ~first_done_q & ~load_busy;
  assign apply       = (vblank & ~vblank_q) | first_apply;

  // Vblank edge detector and one-shot apply once the reset load has finished.
  always_ff @(posedge clk) begin
    if (reset) begin
      vblank_q     <= 1'b0;
      first_done_q <= 1'b0;
    end else begin
      vblank_q <= vblank;
      if (first_apply) begin
        first_done_q <= 1'b1;
      end
    end
  end
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign apply         = 1'b1;
`endif

  // Live settings view for the mapper, refreshed from the store when allowed.
  always_ff @(posedge clk) begin
    if (reset) begin
      view_q <= '0;
      game_q <= 8'h00;
    end else if (apply) begin
      view_q <= store_q;
      game_q <= store_q[GAME_INDEX];
    end
  end

  // Ready flag follows the loader with one register stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      dip_ready <= 1'b0;
    end else begin
      dip_ready <= ~load_busy;
    end
  end

  assign dip_entries = view_q;
  assign game        = game_q;

endmodule

// File: tb/tb_athena_dip_seq.sv
// Testbench for athena_dip_seq: directed bridge traffic checked every cycle
// against a behavioural model of the settings store and loader, plus literal
// expectations at the interesting points of each scenario.
module tb_athena_dip_seq;

  localparam logic [7:0] ATHENA_TBL [15] = '{
    8'h3C, 8'h01, 8'h02, 8'h10, 8'h20, 8'h03, 8'h41, 8'h08,
    8'h04, 8'h50, 8'h81, 8'h0F, 8'h05, 8'h66, 8'h07
  };
  localparam logic [7:0] GOLF_TBL [15] = '{
    8'h11, 8'h22, 8'h33, 8'h44, 8'h05, 8'h06, 8'h17, 8'h18,
    8'h09, 8'h1A, 8'h0B, 8'h0C, 8'h00, 8'h00, 8'h00
  };

  logic         clk = 1'b0;
  logic         reset;
  logic         vblank;
  logic [127:0] dip_entries;
  logic [7:0]   game;
  logic         dip_ready;
  logic         load_busy;

  int n_vec;
  int n_miss;

  athena_dip_seq_if bus ();

  athena_dip_seq dut (
    .clk         (clk),
    .reset       (reset),
    .bridge      (bus.slave),
    .vblank      (vblank),
    .dip_entries (dip_entries),
    .game        (game),
    .dip_ready   (dip_ready),
    .load_busy   (load_busy)
  );

  // Free-running core clock.
  always #5 clk = ~clk;

  function automatic logic [7:0] tbDefault(logic [7:0] g, int i);
    if (g == 8'h01) return GOLF_TBL[i];
    return ATHENA_TBL[i];
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state: the store, the pending load and the expected outputs.
  logic [7:0]  m_store [16];
  logic        m_busy;
  int          m_pos;
  logic [14:0] m_dirty;
  logic [7:0]  m_tgt;
  logic        m_vb_q;
  logic        m_first;
  logic [31:0] e_rd_data;
  logic        e_valid;
  logic [7:0]  e_dip [16];
  logic [7:0]  e_game;
  logic        e_ready;

  // Model advance at each clock: outputs reflect the state before this cycle's writes.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        m_store[i] = 8'h00;
        e_dip[i]   = 8'h00;
      end
      m_busy = 1'b1; m_pos = 0; m_dirty = '0; m_tgt = 8'h00;
      m_vb_q = 1'b0; m_first = 1'b0;
      e_rd_data = 32'h0; e_valid = 1'b0; e_game = 8'h00; e_ready = 1'b0;
    end else begin
      e_rd_data = {24'h0, m_store[bus.addr]};
      e_valid   = bus.rd;
`ifdef ATHENA_DIP_VBLANK_APPLY_EN
      if ((vblank && !m_vb_q) || (!m_first && !m_busy)) begin
        e_dip  = m_store;
        e_game = m_store[15];
      end
      if (!m_first && !m_busy) m_first = 1'b1;
      m_vb_q = vblank;
`else
      e_dip  = m_store;
      e_game = m_store[15];
`endif
      e_ready = !m_busy;
      if (bus.wr) begin
        m_store[bus.addr] = bus.wr_data;
        if (bus.addr == 4'd15 && bus.wr_data != m_tgt) begin
          m_busy = 1'b1; m_pos = 0; m_dirty = '0; m_tgt = bus.wr_data;
        end else if (m_busy && bus.addr < 4'd15) begin
          m_dirty[bus.addr] = 1'b1;
        end
      end else if (m_busy) begin
        if (!m_dirty[m_pos]) m_store[m_pos] = tbDefault(m_tgt, m_pos);
        m_pos++;
        if (m_pos == 15) m_busy = 1'b0;
      end
    end
  end

  // Compare process: every output against the model, away from the active edge.
  always @(negedge clk) begin
    logic [127:0] exp_pk;
    for (int i = 0; i < 16; i++) exp_pk[8*i +: 8] = e_dip[i];
    checkOutput("rd_data", {96'h0, bus.rd_data}, {96'h0, e_rd_data});
    checkOutput("rd_data_valid", {127'h0, bus.rd_data_valid}, {127'h0, e_valid});
    checkOutput("dip_entries", dip_entries, exp_pk);
    checkOutput("game", {120'h0, game}, {120'h0, e_game});
    checkOutput("dip_ready", {127'h0, dip_ready}, {127'h0, e_ready});
    checkOutput("load_busy", {127'h0, load_busy}, {127'h0, m_busy});
  end

  task automatic applyStimulus(input logic wr, input logic rd, input logic [3:0] addr, input logic [7:0] data);
    bus.wr = wr; bus.rd = rd; bus.addr = addr; bus.wr_data = data;
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'd0, 8'h00);
  endtask

  task automatic frameTick();
    vblank = 1'b1; idle(1);
    vblank = 1'b0; idle(1);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (load_busy && n < 100) begin n++; idle(1); end
    checkOutput("load_done", {127'h0, load_busy}, 128'h0);
  endtask

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  // Directed scenarios.
  initial begin
    int busy_n;
    int rdy_n;
    n_vec = 0; n_miss = 0;
    reset = 1'b1; vblank = 1'b0;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.addr = 4'd0; bus.wr_data = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_ready", {127'h0, dip_ready}, 128'h0);
    checkOutput("reset_game", {120'h0, game}, 128'h0);
    reset = 1'b0;

    // Reset load with no bridge traffic.
    busy_n = 0;
    while (load_busy && busy_n < 100) begin busy_n++; idle(1); end
    checkOutput("reset_busy_cycles", busy_n, 15);
    checkOutput("reset_ready_pre16", {127'h0, dip_ready}, 128'h0);
    idle(1);
    checkOutput("reset_ready_16", {127'h0, dip_ready}, 128'h1);
    idle(2);
    checkOutput("reset_entry0", {120'h0, dip_entries[7:0]}, 128'h3C);
    checkOutput("reset_entry14", {120'h0, dip_entries[119:112]}, 128'h07);
    checkOutput("reset_game0", {120'h0, game}, 128'h0);

    // Select fighting_golf from idle.
    applyStimulus(1'b1, 1'b0, 4'd15, 8'h01);
    busy_n = 0; rdy_n = 0;
    for (int k = 0; k < 20; k++) begin
      if (load_busy) busy_n++;
      if (!dip_ready) rdy_n++;
      idle(1);
    end
    checkOutput("golf_busy_cycles", busy_n, 15);
    checkOutput("golf_ready_low", rdy_n, 15);
    frameTick();
    checkOutput("golf_entry0", {120'h0, dip_entries[7:0]}, 128'h11);
    checkOutput("golf_entry11", {120'h0, dip_entries[95:88]}, 128'h0C);
    checkOutput("golf_game", {120'h0, game}, 128'h01);

    // Host write to entry 3 while the loader sits at index 1.
    applyStimulus(1'b1, 1'b0, 4'd15, 8'h00);
    busy_n = 0;
    for (int k = 0; k < 20; k++) begin
      if (load_busy) busy_n++;
      if (k == 1) applyStimulus(1'b1, 1'b0, 4'd3, 8'hA5);
      else idle(1);
    end
    checkOutput("stall_busy_cycles", busy_n, 16);
    frameTick();
    checkOutput("dirty_entry3", {120'h0, dip_entries[31:24]}, 128'hA5);
    checkOutput("athena_entry4", {120'h0, dip_entries[39:32]}, 128'h20);

    // Game select flips at index 7, then a same-value write mid-load.
    applyStimulus(1'b1, 1'b0, 4'd15, 8'h01);
    idle(7);
    applyStimulus(1'b1, 1'b0, 4'd15, 8'h00);
    applyStimulus(1'b1, 1'b0, 4'd15, 8'h01);
    busy_n = 0;
    for (int k = 0; k < 20; k++) begin
      if (load_busy) busy_n++;
      if (k == 3) applyStimulus(1'b1, 1'b0, 4'd15, 8'h01);
      else idle(1);
    end
    checkOutput("restart_busy_cycles", busy_n, 16);
    frameTick();
    checkOutput("restart_entry0", {120'h0, dip_entries[7:0]}, 128'h11);
    checkOutput("restart_entry3", {120'h0, dip_entries[31:24]}, 128'h44);
    checkOutput("restart_game", {120'h0, game}, 128'h01);

    // Read-during-write returns the old value; a later read sees the new one.
    applyStimulus(1'b1, 1'b0, 4'd15, 8'h00);
    waitIdle();
    applyStimulus(1'b1, 1'b1, 4'd15, 8'h01);
    checkOutput("rdw_old_data", {96'h0, bus.rd_data}, 128'h0);
    checkOutput("rdw_valid", {127'h0, bus.rd_data_valid}, 128'h1);
    applyStimulus(1'b0, 1'b0, 4'd15, 8'h00);
    checkOutput("rd_valid_drop", {127'h0, bus.rd_data_valid}, 128'h0);
    applyStimulus(1'b0, 1'b1, 4'd15, 8'h00);
    checkOutput("rd_new_data", {96'h0, bus.rd_data}, 128'h1);
    checkOutput("rd_new_valid", {127'h0, bus.rd_data_valid}, 128'h1);
    waitIdle();
    frameTick();

    // Mid-frame host write to entry 2.
    applyStimulus(1'b1, 1'b0, 4'd2, 8'h03);
    checkOutput("mid_entry2_old", {120'h0, dip_entries[23:16]}, 128'h33);
`ifdef ATHENA_DIP_VBLANK_APPLY_EN
    idle(3);
    checkOutput("vb_entry2_held", {120'h0, dip_entries[23:16]}, 128'h33);
    vblank = 1'b1;
    idle(1);
    checkOutput("vb_entry2_applied", {120'h0, dip_entries[23:16]}, 128'h03);
    vblank = 1'b0;
`else
    idle(1);
    checkOutput("mid_entry2_new", {120'h0, dip_entries[23:16]}, 128'h03);
`endif
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
